// File: rtl/cbrt_dispatch_pkg.sv
// Shared types and widths for the cbrt job dispatcher.
package cbrt_dispatch_pkg;

    localparam int unsigned OPERAND_W = 8;
    localparam int unsigned ROOT_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/cbrt_fifo.sv
// Synchronous operand FIFO; head is registered storage, so no fall-through.
module cbrt_fifo
    import cbrt_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = OPERAND_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/cbrt_dispatch.sv
// Sequences buffered operands through the cbrt core one job at a time and
// returns each root, paired with its operand, on a valid/ready stream.
module cbrt_dispatch
    import cbrt_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPERAND_W-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OPERAND_W-1:0]   out_x,
    output logic [ROOT_W-1:0]      out_root,
    output logic                   out_err,
    output logic [OPERAND_W-1:0]   core_x,
    output logic                   core_start,
    input  logic                   core_busy,
    input  logic [ROOT_W-1:0]      core_result,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [OPERAND_W-1:0]   head;
    logic                   push;
    logic                   pop;

    assign in_ready = (fifo_level != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == ST_ISSUE);

    cbrt_fifo #(
        .DEPTH (DEPTH),
        .W     (OPERAND_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .head  (head),
        .level (fifo_level)
    );

    // core_start/core_x are loaded on the IDLE->ISSUE edge so they are
    // registered outputs that are valid exactly during the ISSUE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            core_start <= 1'b0;
            core_x     <= '0;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_root   <= '0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_level != '0) begin
                        state      <= ST_ISSUE;
                        core_start <= 1'b1;
                        core_x     <= head;
                    end
                end
                ST_ISSUE: begin
                    core_start <= 1'b0;
                    cnt        <= '0;
                    state      <= ST_GUARD;
                end
                ST_GUARD: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A result arriving on the final cycle beats the timeout.
                    if (!core_busy) begin
                        out_root  <= core_result;
                        out_x     <= core_x;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        out_root  <= '0;
                        out_x     <= core_x;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cbrt_dispatch.md
Name: cbrt_dispatch

Overview:
Job sequencer that sits directly upstream of the cbrt core and also consumes its output. Buffers incoming 8-bit operands in a small FIFO and issues them one at a time over the core's start/busy handshake. Captures each 3-bit root and presents it, paired with its operand, on a valid/ready output stream. The core's shared sum adder wiring stays outside this block.

Parameters:
DEPTH, 4, input FIFO depth in entries; power of two, minimum 2.
TIMEOUT, 255, maximum WAIT cycles before a job is aborted; minimum 1, counter width clog2(TIMEOUT+1).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted at 0)
in_valid  input  1  operand offered
in_ready  output  1  operand accepted when in_valid && in_ready
in_data  input  8  operand x
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_x  output  8  operand belonging to this result
out_root  output  3  floor cube root from core; 0 on timeout
out_err  output  1  1 = job aborted by timeout
core_x  output  8  to cbrt x_i
core_start  output  1  to cbrt start
core_busy  input  1  from cbrt busy
core_result  input  3  from cbrt result
fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, fifo_level=0, state IDLE, core_start=0, core_x=0, out_valid=0, out_x=0, out_root=0, out_err=0, timeout counter=0. in_ready=1 once reset is released. Reset during any state aborts the job in flight; the core is expected to be reset by the same rst net.
- FIFO: in_ready = (level != DEPTH). Push on in_valid && in_ready. Pop only in ISSUE. Pointers wrap modulo DEPTH. Simultaneous push and pop leaves level unchanged. Not fall-through: a push into an empty FIFO makes the head visible the next cycle.
- FSM states: IDLE, ISSUE, GUARD, WAIT, OUT.
- IDLE: if level != 0, go to ISSUE.
- ISSUE (1 cycle): core_start=1, core_x=head (registered), pop, clear timeout counter, go to GUARD.
- GUARD (1 cycle): core_start=0; core_busy ignored; go to WAIT. core_x is held stable from ISSUE until leaving WAIT.
- WAIT, each cycle, first matching rule applies:
  - core_busy=0: latch out_root=core_result, out_x=core_x, out_err=0; go to OUT.
  - Counter == TIMEOUT-1: latch out_root=0, out_x=core_x, out_err=1; go to OUT.
  - Otherwise: increment counter.
  - If busy drops on the timeout cycle, the result wins (busy has priority).
- OUT: out_valid=1; out_x, out_root and out_err are held stable while out_ready=0. On out_ready=1, go to IDLE (out_valid=0 next cycle). No issue overlap: the next job enters ISSUE at the earliest one cycle after the handshake.
- Latency: from the ISSUE cycle, out_valid rises one cycle after the WAIT cycle that samples core_busy=0.
- core_start is never asserted outside ISSUE. At most one job is outstanding at the core.
- Arithmetic: only pointer, level and counter arithmetic; no data transformation.

Decomposition:
- Shared package: FSM state encoding (3-bit localparams), OPERAND_W=8, ROOT_W=3.
- One natural sub-module: cbrt_fifo (sync FIFO, parameter DEPTH, push/pop/level/head).
- FSM, timeout counter and output register live in cbrt_dispatch.

Test Plan:
- Single job, out_ready=1, real cbrt+sum: push 27 -> one out_valid pulse with out_x=27, out_root=3, out_err=0; core_start high for exactly 1 cycle.
- Back-to-back push of 8, 64, 125, 216 on consecutive cycles -> outputs in order with roots 2, 4, 5, 6; fifo_level peaks at 3 or 4; no second core_start while a job is outstanding.
- Backpressure, DEPTH=4: hold out_ready=0 and push 6 operands -> first result held stable in OUT; 4 queued; in_ready=0 with level=4. Release out_ready -> all 5 accepted jobs drain in order; the 6th is accepted once space frees.
- Timeout, TIMEOUT=16, core stub with busy stuck at 1: push 100 -> out_valid after 16 WAIT cycles with out_x=100, out_root=0, out_err=1. The next job with a working stub completes normally with out_err=0.
- Reset mid-operation: assert rst=0 during WAIT with 2 entries queued -> immediately out_valid=0, core_start=0, fifo_level=0. After release, push 64 -> out_root=4.
- Boundaries: push 0 -> out_root=0; push 255 -> out_root=6; push 1 -> out_root=1.
